// File: rtl/jk_cmd_arbiter_if.sv
// Handshake and JK-bank bus between two command requesters and the arbiter.
interface jk_cmd_arbiter_if #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 16
);
  logic              req0;
  logic              req1;
  logic [1:0]        cmd0;
  logic [1:0]        cmd1;
  logic [N_BITS-1:0] mask0;
  logic [N_BITS-1:0] mask1;
  logic              ack0;
  logic              ack1;
  logic              busy;
  logic [N_BITS-1:0] j;
  logic [N_BITS-1:0] k;
  logic [N_BITS-1:0] q;
  logic [CNT_W-1:0]  txn_count;

  modport master (
    output req0, req1, cmd0, cmd1, mask0, mask1,
    input  ack0, ack1, busy, j, k, q, txn_count
  );

  modport slave (
    input  req0, req1, cmd0, cmd1, mask0, mask1,
    output ack0, ack1, busy, j, k, q, txn_count
  );
endinterface

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter granting two requesters JK-style set/clear/toggle access to a shared bank.
// state | meaning
// IDLE  | waiting for a request; winner, cmd and mask are latched on grant
// EXEC  | j/k driven from latched cmd/mask; q takes the JK update on the exit edge
// ACK   | single-cycle ack to the granted requester; txn_count bumps on the exit edge
module jk_cmd_arbiter #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  jk_cmd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              owner;
  logic              grant_sel;
  logic              any_req;
  logic [1:0]        cmd_l;
  logic [N_BITS-1:0] mask_l;
  logic [N_BITS-1:0] q_r;
  logic [N_BITS-1:0] j_c;
  logic [N_BITS-1:0] k_c;
  logic [CNT_W-1:0]  cnt;
  logic              ack0_c;
  logic              ack1_c;
  logic              busy_c;

  // On a tie the requester not granted last time wins.
  assign any_req   = bus.req0 | bus.req1;
  assign grant_sel = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_l      <= 2'b00;
      mask_l     <= '0;
    end else if (state == IDLE && any_req) begin
      last_grant <= grant_sel;
      owner      <= grant_sel;
      cmd_l      <= grant_sel ? bus.cmd1  : bus.cmd0;
      mask_l     <= grant_sel ? bus.mask1 : bus.mask0;
    end
  end

  // JK rule per bit: q+ = j&~q | ~k&q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              q_r <= '0;
    else if (state == EXEC) q_r <= (j_c & ~q_r) | (~k_c & q_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (state == ACK) cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    j_c       = '0;
    k_c       = '0;
    ack0_c    = 1'b0;
    ack1_c    = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = EXEC;
      end
      EXEC: begin
        busy_c    = 1'b1;
        j_c       = mask_l & {N_BITS{cmd_l[1]}};
        k_c       = mask_l & {N_BITS{cmd_l[0]}};
        state_nxt = ACK;
      end
      ACK: begin
        busy_c    = 1'b1;
        ack0_c    = ~owner;
        ack1_c    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ack0      = ack0_c;
  assign bus.ack1      = ack1_c;
  assign bus.busy      = busy_c;
  assign bus.j         = j_c;
  assign bus.k         = k_c;
  assign bus.q         = q_r;
  assign bus.txn_count = cnt;
endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Self-checking bench: directed vector table, reset/wrap sequences, then random traffic vs a bank model.
module tb_jk_cmd_arbiter;
  localparam int NB = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jk_cmd_arbiter_if #(.N_BITS(NB), .CNT_W(CW)) bus ();
  jk_cmd_arbiter #(.N_BITS(NB), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int q_m;
  int cnt_m;
  int last_m;

  typedef struct {
    bit r0; bit r1;
    int c0; int m0;
    int c1; int m1;
    int exp_w;
    int exp_q;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int next_q(input int qv, input int c, input int m);
    case (c & 3)
      1:       return qv & ~m & 'hFF;
      2:       return (qv | m) & 'hFF;
      3:       return (qv ^ m) & 'hFF;
      default: return qv;
    endcase
  endfunction

  // Drives one request set and follows it through grant, EXEC, ACK and back to IDLE.
  // ew/eq >= 0 override the model's predicted winner / result q.
  task automatic run_txn(input bit r0, input bit r1, input int c0, input int m0,
                         input int c1, input int m1, input int ew, input int eq);
    int w, c, m, qe;
    bus.req0  = r0;
    bus.req1  = r1;
    bus.cmd0  = c0[1:0];
    bus.mask0 = m0[7:0];
    bus.cmd1  = c1[1:0];
    bus.mask1 = m1[7:0];
    if (!r0 && !r1) begin
      @(posedge clk); #1;
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_q", int'(bus.q), q_m);
      return;
    end
    w  = (r0 && r1) ? ((last_m == 0) ? 1 : 0) : (r1 ? 1 : 0);
    if (ew >= 0) w = ew;
    c  = w ? c1 : c0;
    m  = (w ? m1 : m0) & 'hFF;
    qe = (eq >= 0) ? eq : next_q(q_m, c, m);
    @(posedge clk); #1;
    chk("exec_busy", int'(bus.busy), 1);
    chk("exec_j", int'(bus.j), (c & 2) ? m : 0);
    chk("exec_k", int'(bus.k), (c & 1) ? m : 0);
    chk("exec_q_hold", int'(bus.q), q_m);
    chk("exec_acks", int'({bus.ack1, bus.ack0}), 0);
    bus.cmd0  = 2'($urandom_range(0, 3));
    bus.cmd1  = 2'($urandom_range(0, 3));
    bus.mask0 = 8'($urandom_range(0, 255));
    bus.mask1 = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    chk("ack_q", int'(bus.q), qe);
    chk("ack0", int'(bus.ack0), (w == 0) ? 1 : 0);
    chk("ack1", int'(bus.ack1), (w == 1) ? 1 : 0);
    chk("ack_busy", int'(bus.busy), 1);
    chk("ack_jk", int'({bus.j, bus.k}), 0);
    q_m    = qe;
    last_m = w;
    cnt_m  = (cnt_m + 1) % 16;
    @(posedge clk); #1;
    chk("done_busy", int'(bus.busy), 0);
    chk("done_acks", int'({bus.ack1, bus.ack0}), 0);
    chk("done_count", int'(bus.txn_count), cnt_m);
    chk("done_q", int'(bus.q), q_m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q_m = 0; cnt_m = 0; last_m = 1;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.cmd0 = 2'b00; bus.cmd1 = 2'b00;
    bus.mask0 = '0; bus.mask1 = '0;
    reset = 1'b1;
    q_m = 0; cnt_m = 0; last_m = 1;

    #12;
    chk("rst_q", int'(bus.q), 0);
    chk("rst_count", int'(bus.txn_count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_acks", int'({bus.ack1, bus.ack0}), 0);
    chk("rst_jk", int'({bus.j, bus.k}), 0);
    @(negedge clk);
    reset = 1'b0;

    tbl[0] = '{1, 0, 2, 'h0F, 0, 'h00, 0, 'h0F};
    tbl[1] = '{0, 1, 0, 'h00, 0, 'hFF, 1, 'h0F};
    tbl[2] = '{1, 1, 3, 'hFF, 1, 'h03, 0, 'hF0};
    tbl[3] = '{1, 1, 3, 'hFF, 1, 'h03, 1, 'hF0};
    tbl[4] = '{1, 1, 3, 'hFF, 1, 'h03, 0, 'h0F};
    tbl[5] = '{1, 0, 3, 'hA5, 0, 'h00, 0, 'hAA};
    tbl[6] = '{0, 1, 0, 'h00, 3, 'hF0, 1, 'h5A};
    tbl[7] = '{1, 0, 0, 'hFF, 0, 'h00, 0, 'h5A};
    tbl[8] = '{0, 1, 0, 'h00, 2, 'h00, 1, 'h5A};
    tbl[9] = '{1, 0, 1, 'h0F, 0, 'h00, 0, 'h50};
    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].r0, tbl[i].r1, tbl[i].c0, tbl[i].m0,
              tbl[i].c1, tbl[i].m1, tbl[i].exp_w, tbl[i].exp_q);
    chk("tbl_count", int'(bus.txn_count), 10);

    // Reset during EXEC aborts the set; both requests held through reset.
    bus.req0 = 1'b1; bus.req1 = 1'b0; bus.cmd0 = 2'b10; bus.mask0 = 8'hFF;
    @(posedge clk); #1;
    chk("mid_exec_busy", int'(bus.busy), 1);
    reset = 1'b1;
    bus.req1 = 1'b1;
    #1;
    chk("mid_rst_q", int'(bus.q), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_acks", int'({bus.ack1, bus.ack0}), 0);
    chk("mid_rst_count", int'(bus.txn_count), 0);
    chk("mid_rst_jk", int'({bus.j, bus.k}), 0);
    @(posedge clk); #1;
    chk("mid_rst_q2", int'(bus.q), 0);
    chk("mid_rst_acks2", int'({bus.ack1, bus.ack0}), 0);
    @(negedge clk);
    reset = 1'b0;
    q_m = 0; cnt_m = 0; last_m = 1;
    run_txn(1, 1, 2, 'h3C, 1, 'hFF, 0, 'h3C);
    run_txn(0, 1, 0, 'h00, 1, 'hFF, 1, 'h00);

    // Counter wrap at 2^CW.
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) run_txn(1, 0, 0, 'hFF, 0, 0, -1, -1);
    chk("wrap_15", int'(bus.txn_count), 15);
    run_txn(1, 0, 0, 'hFF, 0, 0, -1, -1);
    chk("wrap_0", int'(bus.txn_count), 0);

    for (int i = 0; i < 300; i++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_cmd_arbiter.md
JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

Interface
REQ-001 Parameter: N_BITS, default 8, width of the shared JK register bank.
REQ-002 Parameter: CNT_W, default 16, width of the transaction counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1 each  request from requester 0 / 1; held high until its ack is sampled.
REQ-006 cmd0 / cmd1  input  2 each  command for requester 0 / 1: 00 hold, 01 clear (K), 10 set (J), 11 toggle (J&K).
REQ-007 mask0 / mask1  input  N_BITS each  bit-select for requester 0 / 1; a 1 applies the command to that bit.
REQ-008 ack0 / ack1  output  1 each  single-cycle completion pulse to requester 0 / 1.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 j / k  output  N_BITS each  per-bit JK drive; nonzero only in EXEC.
REQ-011 q  output  N_BITS  registered state of the shared JK bank.
REQ-012 txn_count  output  CNT_W  number of completed transactions.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and ACK.
REQ-014 IDLE SHALL go to EXEC on a clk edge where req0 or req1 is high; otherwise it SHALL stay in IDLE.
REQ-015 EXEC SHALL always go to ACK on the next edge, and ACK SHALL always go to IDLE on the next edge.
REQ-016 On the IDLE->EXEC edge, the block SHALL latch the winner's index, cmd and mask.
REQ-017 Arbitration SHALL be round-robin: if only one req is high, that requester wins; if both are high, the requester not granted last wins.
REQ-018 The last-grant register SHALL reset to 1, so requester 0 wins the first tie after reset.
REQ-019 In EXEC, per bit i, j[i] SHALL equal mask[i] & cmd[1] and k[i] SHALL equal mask[i] & cmd[0], using the latched values; j and k SHALL be all-zero in IDLE and ACK.
REQ-020 On the EXEC->ACK edge, each q[i] SHALL update by the JK rule:
- j=1, k=0 -> 1
- j=0, k=1 -> 0
- j=1, k=1 -> invert
- j=0, k=0 -> hold
REQ-021 q SHALL change on no other edge.
REQ-022 The granted requester's ack SHALL be high for exactly the ACK cycle; the other ack SHALL stay low.
REQ-023 txn_count SHALL increment by 1 on the ACK->IDLE edge and SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 Latency SHALL be fixed: request sampled at edge E, q updated at E+1, ack high between E+1 and E+2, next grant possible at E+3.
REQ-025 Requests arriving while busy SHALL NOT be lost while held; a req still high in IDLE SHALL be treated as a new request.
REQ-026 Changes to cmdX or maskX after the grant edge SHALL have no effect on the current transaction.
REQ-027 A transaction with mask=0 or cmd=00 SHALL complete the full handshake with q unchanged, and SHALL increment txn_count.
REQ-028 Bits with mask=0 SHALL hold their value in every transaction.

Reset
REQ-029 While reset is high, the block SHALL immediately force:
- state = IDLE
- q = 0, txn_count = 0
- ack0 = ack1 = 0, busy = 0
- j = k = 0
- last-grant = 1
REQ-030 Reset asserted in EXEC or ACK SHALL abort the transaction with no q update, no ack and no count increment.
REQ-031 The first edge after reset deassertion SHALL be able to grant a held request.

Verification
REQ-032 Single set: N_BITS=8, after reset, req0=1, cmd0=10, mask0=0x0F -> q=0x0F at E+1, ack0 high one cycle, txn_count=1, ack1 never high.
REQ-033 Tie round-robin: q=0x0F, req0 and req1 held high, cmd0=11 mask0=0xFF, cmd1=01 mask1=0x03 -> grant order req0 (q=0xF0), then req1 (q=0xF0), then req0 (q=0x0F); acks alternate ack0, ack1, ack0.
REQ-034 Toggle/hold mix: q=0xAA, cmd=11, mask=0xF0 -> q=0x5A; bits 3:0 unchanged.
REQ-035 Null transaction: cmd=00, mask=0xFF -> q unchanged, ack pulses, txn_count increments, busy high exactly 2 cycles.
REQ-036 Reset mid-operation: assert reset during EXEC with cmd=10 mask=0xFF -> q=0, no ack, txn_count unchanged at 0; a held req1 after release wins the next tie against req0 only if req0 is low (req0 wins a tie).
REQ-037 Counter wrap: CNT_W=4, run 16 transactions -> txn_count reads 0 after the 16th ACK->IDLE edge.
